// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stage-boundary bundle for pipe_stage_reg: upstream beat in, downstream beat out.
// The master side belongs to the surrounding pipeline; the slave side belongs to the stage register.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready flow control, flush-to-bubble and stall counter.
// Define PIPE_REG_SKID_EN to add a skid entry that registers in_ready (no out_ready->in_ready path).
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  pipe_stage_reg_if.slave   bus,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_main_vld;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CNT_W-1:0]  r_stall_cnt;

`ifdef PIPE_REG_SKID_EN
  logic              r_skid_vld;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_in_ready;

  // Stage FSM; in_ready is a flop that mirrors "skid entry free"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main_vld  <= 1'b0;
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_main_data <= {DATA_W{1'b0}};
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= {CTRL_W{1'b0}};
      r_skid_data <= {DATA_W{1'b0}};
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_main_vld  <= 1'b0;
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= {CTRL_W{1'b0}};
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (bus.in_valid) begin
            r_main_vld  <= 1'b1;
            r_main_ctrl <= bus.in_ctrl;
            r_main_data <= bus.in_data;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.in_valid && bus.out_ready) begin
            r_main_ctrl <= bus.in_ctrl;
            r_main_data <= bus.in_data;
          end else if (bus.in_valid) begin
            r_skid_vld  <= 1'b1;
            r_skid_ctrl <= bus.in_ctrl;
            r_skid_data <= bus.in_data;
            r_in_ready  <= 1'b0;
            r_state     <= ST_FULL;
          end else if (bus.out_ready) begin
            r_main_vld  <= 1'b0;
            r_main_ctrl <= {CTRL_W{1'b0}};
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
            r_skid_vld  <= 1'b0;
            r_skid_ctrl <= {CTRL_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_main_vld  <= 1'b0;
          r_main_ctrl <= {CTRL_W{1'b0}};
          r_skid_vld  <= 1'b0;
          r_skid_ctrl <= {CTRL_W{1'b0}};
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign occupancy    = {1'b0, r_main_vld} + {1'b0, r_skid_vld};
`else
  // Stage FSM without skid: a held beat blocks input until it is taken downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main_vld  <= 1'b0;
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_main_data <= {DATA_W{1'b0}};
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_main_vld  <= 1'b0;
      r_main_ctrl <= {CTRL_W{1'b0}};
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (bus.in_valid) begin
            r_main_vld  <= 1'b1;
            r_main_ctrl <= bus.in_ctrl;
            r_main_data <= bus.in_data;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.out_ready && bus.in_valid) begin
            r_main_ctrl <= bus.in_ctrl;
            r_main_data <= bus.in_data;
          end else if (bus.out_ready) begin
            r_main_vld  <= 1'b0;
            r_main_ctrl <= {CTRL_W{1'b0}};
            r_state     <= ST_EMPTY;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_main_vld  <= 1'b0;
          r_main_ctrl <= {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready = !r_main_vld || bus.out_ready;
  assign occupancy    = {1'b0, r_main_vld};
`endif

  // Saturating stall counter; survives flush, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (r_main_vld && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.out_valid = r_main_vld;
  assign bus.out_ctrl  = r_main_ctrl & {CTRL_W{r_main_vld}};
  assign bus.out_data  = r_main_data;
  assign stall_cnt     = r_stall_cnt;

endmodule
